fpu_add_seq: RTL and testbench
==============================

Name: fpu_add_seq

Overview:
- Multi-cycle IEEE-754 single-precision adder controller.
- Accepts an operand pair over a valid/ready handshake and sequences the extended-mantissa add/subtract datapath through unpack, special-case, align, add, normalise, round and pack states.
- Returns the packed result over a second valid/ready handshake.
- Sits between the FPU issue logic and the FPU result bus; one operation in flight at a time.

Parameters:
- ALIGN_LIMIT, 27, exponent difference at or above which alignment collapses the smaller mantissa to sticky-only in a single cycle.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair a/b valid
- in_ready  output  1  block idle and accepting operands
- a  input  32  operand A, float32
- b  input  32  operand B, float32
- out_valid  output  1  result z valid
- out_ready  input  1  consumer accepts z
- z  output  32  result, float32
- state_out  output  4  current FSM state encoding, for debug/verification

Behaviour:
- Reset (rst high at clock edge): state=get_input, in_ready=1, out_valid=0, z=0, all internal mantissa/exponent registers 0. Applies mid-operation: any in-flight operation is discarded, no result produced.
- State encodings: get_input=0, unpack=1, special=2, align=3, add_0=4, add_1=5, normalise_1=6, normalise_2=7, round=8, pack=9, put_z=10. Encodings 11-15 are illegal and go to get_input on the next edge.
- get_input: in_ready=1. On in_valid&in_ready, latch a/b, clear in_ready, go to unpack.
- unpack: split sign, exponent (unbiased, 10-bit signed, bias 127) and 27-bit mantissa {hidden, frac[22:0], guard, round, sticky=000}. Hidden bit is 1 unless exp field=0. Denormal inputs are flushed to signed zero.
- special (first matching rule, then jump to put_z):
  - either operand NaN -> 0x7FC00000.
  - inf + inf of opposite sign -> 0x7FC00000.
  - either operand inf -> that inf.
  - both zero -> sign is AND of the operand signs, i.e. +0 unless both are -0.
  - one operand zero -> the other operand.
  - otherwise go to align.
- align: one cycle per step. If exponents are equal, go to add_0. Otherwise:
  - diff >= ALIGN_LIMIT: smaller mantissa becomes {26'b0, sticky=OR of its bits}, its exponent is set to the larger one.
  - else: shift the smaller mantissa right by 1, OR the shifted-out bit into bit 0 (sticky), increment its exponent.
- add_0: z_e = a_e. On equal signs, sum[27:0] = a_m + b_m, z_s = a_s. Otherwise sum = larger - smaller, with a_m >= b_m selecting a; z_s = sign of the larger.
- add_1:
  - sum[27]=1: z_m = sum[27:4], guard = sum[3], round = sum[2], sticky = sum[1]|sum[0], z_e = z_e + 1.
  - else: z_m = sum[26:3], guard = sum[2], round = sum[1], sticky = sum[0].
- normalise_1:
  - sum == 0 (exact cancellation): result +0, jump to pack.
  - z_m[23]=0 and z_e > -126: shift {z_m, guard} left by 1, z_e - 1, stay.
  - else: go to normalise_2.
- normalise_2: if z_e < -126 or z_m[23]=0, the result underflows to signed zero: jump to pack with zero flag set. Else go to round.
- round: round-to-nearest-even. Increment z_m when guard & (round | sticky | z_m[0]). On carry-out (z_m was 0xFFFFFF), z_m = 0x800000 and z_e + 1.
- pack:
  - z_e > 127: {z_s, 8'hFF, 23'b0}.
  - zero flag set: {z_s, 31'b0}.
  - else: {z_s, z_e+127, z_m[22:0]}.
- put_z: out_valid=1, z stable. On out_ready, out_valid=0, in_ready=1, go to get_input. With out_ready low, hold indefinitely and ignore in_valid.
- Latency (accept edge to out_valid high):
  - normal path with equal exponents and no normalise shifts: 10 cycles.
  - special path: 3 cycles.
  - each align step or normalise_1 shift adds 1 cycle.
- No back-to-back issue: in_ready stays low from the accept edge until the edge after out_valid&out_ready.

Test Plan:
- a=0x3F800000, b=0x3F800000, out_ready=1 -> out_valid high 10 cycles after accept, z=0x40000000, state_out sequence 0,1,2,3,4,5,6,7,8,9,10,0.
- a=0x3F800000, b=0xBF800000 -> z=0x00000000. a=0x3F800000, b=0x33800000 (tie) -> z=0x3F800000, latency 10+24 align cycles.
- a=0x7FC00000, b=0x3F800000 -> z=0x7FC00000 after 3 cycles. a=0x7F800000, b=0xFF800000 -> z=0x7FC00000.
- a=0x7F7FFFFF, b=0x7F7FFFFF -> z=0x7F800000. a=0x40400000, b=0xBF800000 -> z=0x40000000.
- out_ready held low 20 cycles in put_z -> out_valid and z held constant, in_ready=0, in_valid pulses ignored; the result completes once out_ready rises.
- rst asserted in align for one cycle -> next edge state_out=0, out_valid=0, in_ready=1. A following op 1.0+1.0 returns 0x40000000.

Source files
------------

// File: rtl/fpu_add_seq.sv
// fpu_add_seq: multi-cycle IEEE-754 single-precision adder.
// Accepts one operand pair at a time and steps it through unpack, special-case
// handling, alignment, add, normalisation, round-to-nearest-even and pack.
// Denormal inputs are flushed to signed zero, and underflowing results are
// flushed to signed zero as well.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (discards any in-flight operation)
//   in_valid   operand pair a/b valid
//   in_ready   idle and accepting operands
//   a, b       float32 operands
//   out_valid  result z valid
//   out_ready  consumer accepts z
//   z          float32 result
//   state_out  current FSM state encoding
module fpu_add_seq #(
  parameter int ALIGN_LIMIT = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z,
  output logic [3:0]  state_out
);

  typedef enum logic [3:0] {
    GET_INPUT   = 4'd0,
    UNPACK      = 4'd1,
    SPECIAL     = 4'd2,
    ALIGN       = 4'd3,
    ADD_0       = 4'd4,
    ADD_1       = 4'd5,
    NORMALISE_1 = 4'd6,
    NORMALISE_2 = 4'd7,
    ROUND       = 4'd8,
    PACK        = 4'd9,
    PUT_Z       = 4'd10
  } state_t;

  state_t state, state_next;

  logic [31:0]        a_r, b_r;
  logic [26:0]        a_m, b_m;
  logic signed [9:0]  a_e, b_e, z_e;
  logic               a_s, b_s, z_s;
  logic [27:0]        sum;
  logic [23:0]        z_m;
  logic               guard, round_bit, sticky, zero_flag;

  // Round-to-nearest-even increment decision.
  function automatic logic round_inc(input logic g, input logic r,
                                     input logic s, input logic lsb);
    return g & (r | s | lsb);
  endfunction

  // Final packing with overflow saturation to infinity and zero flush.
  function automatic logic [31:0] pack_result(input logic sgn,
                                              input logic signed [9:0] e,
                                              input logic [23:0] m,
                                              input logic zf);
    logic signed [9:0] eb;
    eb = e + 10'sd127;
    if (e > 10'sd127)
      return {sgn, 8'hFF, 23'b0};
    else if (zf)
      return {sgn, 31'b0};
    else
      return {sgn, eb[7:0], m[22:0]};
  endfunction

  // Operand classification straight from the latched encodings.
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign a_nan  = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'b0);
  assign b_nan  = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'b0);
  assign a_inf  = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'b0);
  assign b_inf  = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'b0);
  assign a_zero = (a_r[30:23] == 8'h00);
  assign b_zero = (b_r[30:23] == 8'h00);

  // Exponent distance for alignment; 11 bits so the subtraction never wraps.
  logic signed [10:0] e_diff;
  logic [10:0]        diff_mag;
  logic               a_larger, collapse;
  assign e_diff   = 11'(a_e) - 11'(b_e);
  assign a_larger = (e_diff > 11'sd0);
  assign diff_mag = a_larger ? 11'(e_diff) : 11'(-e_diff);
  assign collapse = (diff_mag >= 11'(ALIGN_LIMIT));

  assign in_ready  = (state == GET_INPUT);
  assign out_valid = (state == PUT_Z);
  assign state_out = state;

  always_comb begin
    state_next = state;
    case (state)
      GET_INPUT:   if (in_valid) state_next = UNPACK;
      UNPACK:      state_next = SPECIAL;
      SPECIAL:     if (a_nan || b_nan || a_inf || b_inf || a_zero || b_zero)
                     state_next = PUT_Z;
                   else
                     state_next = ALIGN;
      ALIGN:       if (a_e == b_e) state_next = ADD_0;
      ADD_0:       state_next = ADD_1;
      ADD_1:       state_next = NORMALISE_1;
      NORMALISE_1: if (sum == 28'b0)
                     state_next = PACK;
                   else if (!(z_m[23] == 1'b0 && z_e > -10'sd126))
                     state_next = NORMALISE_2;
      NORMALISE_2: if (z_e < -10'sd126 || z_m[23] == 1'b0)
                     state_next = PACK;
                   else
                     state_next = ROUND;
      ROUND:       state_next = PACK;
      PACK:        state_next = PUT_Z;
      PUT_Z:       if (out_ready) state_next = GET_INPUT;
      default:     state_next = GET_INPUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= GET_INPUT;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0; b_r <= '0; a_m <= '0; b_m <= '0;
      a_e <= '0; b_e <= '0; z_e <= '0;
      a_s <= 1'b0; b_s <= 1'b0; z_s <= 1'b0;
      sum <= '0; z_m <= '0; z <= '0;
      guard <= 1'b0; round_bit <= 1'b0; sticky <= 1'b0; zero_flag <= 1'b0;
    end else begin
      case (state)
        GET_INPUT: if (in_valid) begin
          a_r <= a;
          b_r <= b;
        end
        UNPACK: begin
          // Zero exponent field (zero or denormal) drops the fraction entirely.
          a_m <= (a_r[30:23] == 8'h00) ? 27'b0 : {1'b1, a_r[22:0], 3'b000};
          b_m <= (b_r[30:23] == 8'h00) ? 27'b0 : {1'b1, b_r[22:0], 3'b000};
          a_e <= $signed({2'b00, a_r[30:23]}) - 10'sd127;
          b_e <= $signed({2'b00, b_r[30:23]}) - 10'sd127;
          a_s <= a_r[31];
          b_s <= b_r[31];
          zero_flag <= 1'b0;
        end
        SPECIAL: begin
          if (a_nan || b_nan)            z <= 32'h7FC00000;
          else if (a_inf && b_inf && (a_s != b_s)) z <= 32'h7FC00000;
          else if (a_inf)                z <= a_r;
          else if (b_inf)                z <= b_r;
          else if (a_zero && b_zero)     z <= {a_s & b_s, 31'b0};
          else if (a_zero)               z <= b_r;
          else if (b_zero)               z <= a_r;
        end
        ALIGN: if (a_e != b_e) begin
          // Far-apart exponents collapse the smaller operand to sticky in one step.
          if (a_larger) begin
            if (collapse) begin
              b_m <= {26'b0, |b_m};
              b_e <= a_e;
            end else begin
              b_m <= {1'b0, b_m[26:2], b_m[1] | b_m[0]};
              b_e <= b_e + 10'sd1;
            end
          end else begin
            if (collapse) begin
              a_m <= {26'b0, |a_m};
              a_e <= b_e;
            end else begin
              a_m <= {1'b0, a_m[26:2], a_m[1] | a_m[0]};
              a_e <= a_e + 10'sd1;
            end
          end
        end
        ADD_0: begin
          z_e <= a_e;
          if (a_s == b_s) begin
            sum <= {1'b0, a_m} + {1'b0, b_m};
            z_s <= a_s;
          end else if (a_m >= b_m) begin
            sum <= {1'b0, a_m} - {1'b0, b_m};
            z_s <= a_s;
          end else begin
            sum <= {1'b0, b_m} - {1'b0, a_m};
            z_s <= b_s;
          end
        end
        ADD_1: begin
          if (sum[27]) begin
            z_m       <= sum[27:4];
            guard     <= sum[3];
            round_bit <= sum[2];
            sticky    <= sum[1] | sum[0];
            z_e       <= z_e + 10'sd1;
          end else begin
            z_m       <= sum[26:3];
            guard     <= sum[2];
            round_bit <= sum[1];
            sticky    <= sum[0];
          end
        end
        NORMALISE_1: begin
          if (sum == 28'b0) begin
            // Exact cancellation always yields +0.
            zero_flag <= 1'b1;
            z_s       <= 1'b0;
          end else if (z_m[23] == 1'b0 && z_e > -10'sd126) begin
            z_m       <= {z_m[22:0], guard};
            guard     <= round_bit;
            round_bit <= 1'b0;
            z_e       <= z_e - 10'sd1;
          end
        end
        NORMALISE_2: if (z_e < -10'sd126 || z_m[23] == 1'b0) zero_flag <= 1'b1;
        ROUND: if (round_inc(guard, round_bit, sticky, z_m[0])) begin
          if (z_m == 24'hFFFFFF) begin
            z_m <= 24'h800000;
            z_e <= z_e + 10'sd1;
          end else begin
            z_m <= z_m + 24'd1;
          end
        end
        PACK: z <= pack_result(z_s, z_e, z_m, zero_flag);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_add_seq.sv
// tb_fpu_add_seq: directed checks of fpu_add_seq with hand-computed results,
// latencies, handshake holding and mid-operation reset.
module tb_fpu_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in, b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;
  logic [3:0]  state_out;

  int total = 0;
  int bad   = 0;

  fpu_add_seq #(.ALIGN_LIMIT(27)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one operation, wait for the result, check value and latency.
  // exp_lat < 0 skips the latency check; seq checks the state walk.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_z, input int exp_lat, input bit seq);
    int lat;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    a_in = av; b_in = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (seq) chk({tag, ".state"}, 32'(state_out), 32'(lat));
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".done"}, 32'(out_valid), 32'd1);
    if (seq) chk({tag, ".state"}, 32'(state_out), 32'd10);
    chk({tag, ".z"}, z, exp_z);
    if (exp_lat >= 0) chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, ".idle"}, {28'b0, state_out}, 32'd0);
      chk({tag, ".rdy_back"}, {31'b0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] zhold;
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", 32'(state_out), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.z", z, 32'd0);
    rst = 1'b0;

    run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000, 10, 1'b1);
    run_op("cancel",       32'h3F800000, 32'hBF800000, 32'h00000000, 8,  1'b0);
    run_op("tie_even",     32'h3F800000, 32'h33800000, 32'h3F800000, 34, 1'b0);
    run_op("tie_odd_up",   32'h3F800001, 32'h33800000, 32'h3F800002, 34, 1'b0);
    run_op("collapse",     32'h3F800000, 32'h30800000, 32'h3F800000, 11, 1'b0);
    run_op("nan",          32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3,  1'b0);
    run_op("inf_minus_inf",32'h7F800000, 32'hFF800000, 32'h7FC00000, 3,  1'b0);
    run_op("inf_plus_one", 32'h3F800000, 32'hFF800000, 32'hFF800000, 3,  1'b0);
    run_op("negz_negz",    32'h80000000, 32'h80000000, 32'h80000000, 3,  1'b0);
    run_op("negz_posz",    32'h80000000, 32'h00000000, 32'h00000000, 3,  1'b0);
    run_op("zero_plus_x",  32'h00000000, 32'h40400000, 32'h40400000, 3,  1'b0);
    run_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 10, 1'b0);
    run_op("three_m_one",  32'h40400000, 32'hBF800000, 32'h40000000, 11, 1'b0);

    // Consumer stalls for 20 cycles; result and handshake must hold.
    out_ready = 1'b0;
    run_op("stall", 32'h3F800000, 32'h3F800000, 32'h40000000, 10, 1'b0);
    zhold = z;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a_in = 32'h40400000; b_in = 32'h40400000; in_valid = i[0];
      @(posedge clk); #1;
      chk("stall.hold", {out_valid, in_ready, 30'b0} ^ (z ^ zhold),
          {1'b1, 1'b0, 30'b0});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall.release", {28'b0, state_out}, 32'd0);
    chk("stall.rdy", {31'b0, in_ready}, 32'd1);
    chk("stall.z", z, 32'h40000000);

    // Reset during alignment discards the operation.
    @(negedge clk);
    a_in = 32'h3F800000; b_in = 32'h33800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (state_out != 4'd3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrst.reach_align", 32'(state_out), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.state", 32'(state_out), 32'd0);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    run_op("after_rst", 32'h3F800000, 32'h3F800000, 32'h40000000, 10, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
